// File: rtl/inst_fetch.sv
// inst_fetch - instruction fetch stage, sits directly after the PC register.
//
// Latches the PC when the PC stage asks for a fetch. It then runs a single
// req/addr_ok/data_ok transaction and hands {pc, inst, exception_type} to
// decode through registered outputs. While a fetch is busy it holds the PC
// stage with fetch_stall_req_o. Responses that belong to flushed fetches are
// dropped.
//
// Ports
//   clock_i, reset_i          clock, synchronous active-high reset
//   pc_i, inst_ren_i          fetch PC and fetch request from the PC stage
//   inst_cache_ena_i          cached (1) / uncached (0) fetch
//   pc_exc_type_i             exception vector from the PC stage
//   flush_i                   kills the fetch in flight and the decode output
//   id_stall_i                decode cannot accept a new instruction
//   inst_req_o/addr_o/cached_o, inst_addr_ok_i/data_ok_i/rdata_i
//                             instruction memory bus
//   id_valid_o/pc_o/inst_o/exc_type_o
//                             decode-side outputs
//   fetch_stall_req_o         PC must hold
//
// Optional build macro INST_FETCH_PERF_EN adds fetch_stall_cycles_o. This
// 32-bit wrapping counter counts the cycles in which fetch_stall_req_o is high.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inst_ren_i,
    input  logic              inst_cache_ena_i,
    input  logic [31:0]       pc_exc_type_i,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_cached_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o,
    output logic [31:0]       id_exc_type_o,
    output logic              fetch_stall_req_o
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_stall_cycles_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_n;
    logic              cancel;
    logic [ADDR_W-1:0] pc_q;

    logic issue;        // start a memory fetch
    logic exc_deliver;  // PC stage flagged an exception: deliver a NOP, no bus access
    logic deliver;      // live read data arriving

    assign issue       = (state == IDLE) && inst_ren_i && !flush_i && (pc_exc_type_i == '0);
    assign exc_deliver = (state == IDLE) && inst_ren_i && !flush_i && (pc_exc_type_i != '0);
    // A flush in the data_ok cycle kills the data, even when cancel is not yet set.
    assign deliver     = (state == WAIT) && inst_data_ok_i && !cancel && !flush_i;

    assign inst_req_o        = (state == REQ);
    assign inst_addr_o       = {pc_q[ADDR_W-1:2], 2'b00};
    assign fetch_stall_req_o = (state == REQ) || (state == WAIT) || cancel;

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (issue)                          state_n = REQ;
                else if (exc_deliver && id_stall_i) state_n = HOLD;
            end
            // The bus forbids withdrawing a request, so a flush does not change the path.
            REQ:  if (inst_addr_ok_i) state_n = WAIT;
            WAIT: if (inst_data_ok_i) state_n = (deliver && id_stall_i) ? HOLD : IDLE;
            HOLD: if (flush_i || !id_stall_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Set cancel when a fetch is flushed mid-flight. The transaction still drains.
    // Cancel clears on its data_ok.
    always_ff @(posedge clock_i) begin
        if (reset_i)
            cancel <= 1'b0;
        else if (state == WAIT && inst_data_ok_i)
            cancel <= 1'b0;
        else if (flush_i && (state == REQ || state == WAIT))
            cancel <= 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q          <= '0;
            inst_cached_o <= 1'b0;
        end else if (issue) begin
            pc_q          <= pc_i;
            inst_cached_o <= inst_cache_ena_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            id_valid_o    <= 1'b0;
            id_pc_o       <= '0;
            id_inst_o     <= '0;
            id_exc_type_o <= '0;
        end else if (flush_i) begin
            id_valid_o    <= 1'b0;
        end else if (deliver) begin
            id_valid_o    <= 1'b1;
            id_pc_o       <= pc_q;
            id_inst_o     <= inst_rdata_i;
            id_exc_type_o <= '0;
        end else if (exc_deliver) begin
            id_valid_o    <= 1'b1;
            id_pc_o       <= pc_i;
            id_inst_o     <= NOP_INST;
            id_exc_type_o <= pc_exc_type_i;
        end else if (!(state == HOLD && id_stall_i)) begin
            // The output is a one-cycle pulse unless decode holds it in HOLD.
            id_valid_o    <= 1'b0;
        end
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clock_i) begin
        if (reset_i)                fetch_stall_cycles_o <= '0;
        else if (fetch_stall_req_o) fetch_stall_cycles_o <= fetch_stall_cycles_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. Inputs are driven 1ns after each rising edge.
// The bus-facing outputs depend only on state, so they are checked in that
// same cycle.
module tb_inst_fetch;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] pc_i = '0;
    logic        inst_ren_i = 1'b0;
    logic        inst_cache_ena_i = 1'b0;
    logic [31:0] pc_exc_type_i = '0;
    logic        flush_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_cached_o;
    logic        inst_addr_ok_i = 1'b0;
    logic        inst_data_ok_i = 1'b0;
    logic [31:0] inst_rdata_i = '0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_exc_type_o;
    logic        fetch_stall_req_o;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_stall_cycles_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch dut (
        .clock_i(clock_i), .reset_i(reset_i), .pc_i(pc_i), .inst_ren_i(inst_ren_i),
        .inst_cache_ena_i(inst_cache_ena_i), .pc_exc_type_i(pc_exc_type_i),
        .flush_i(flush_i), .id_stall_i(id_stall_i), .inst_req_o(inst_req_o),
        .inst_addr_o(inst_addr_o), .inst_cached_o(inst_cached_o),
        .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
        .inst_rdata_i(inst_rdata_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o), .id_exc_type_o(id_exc_type_o),
        .fetch_stall_req_o(fetch_stall_req_o)
`ifdef INST_FETCH_PERF_EN
        , .fetch_stall_cycles_o(fetch_stall_cycles_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        tick; tick;
        reset_i = 1'b0;
        check("rst_valid", id_valid_o, 0);
        check("rst_req", inst_req_o, 0);
        check("rst_addr", inst_addr_o, 0);
        check("rst_inst", id_inst_o, 0);
        check("rst_stall", fetch_stall_req_o, 0);

        // best-case fetch
        pc_i = 32'hbfc00000; inst_ren_i = 1; inst_cache_ena_i = 0;
        check("t1_req_idle", inst_req_o, 0);
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        check("t1_req", inst_req_o, 1);
        check("t1_addr", inst_addr_o, 32'hbfc00000);
        check("t1_stall_req", fetch_stall_req_o, 1);
        tick; inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h3c08bfc0;
        check("t1_req_wait", inst_req_o, 0);
        check("t1_stall_wait", fetch_stall_req_o, 1);
        tick; inst_data_ok_i = 0;
        check("t1_valid", id_valid_o, 1);
        check("t1_pc", id_pc_o, 32'hbfc00000);
        check("t1_inst", id_inst_o, 32'h3c08bfc0);
        check("t1_stall_idle", fetch_stall_req_o, 0);
        tick;
        check("t1_pulse", id_valid_o, 0);

        // exception from PC stage: NOP delivered, no bus access
        pc_i = 32'hbfc00002; pc_exc_type_i = 32'h80000000; inst_ren_i = 1;
        tick; inst_ren_i = 0; pc_exc_type_i = 0;
        check("t2_noreq", inst_req_o, 0);
        check("t2_valid", id_valid_o, 1);
        check("t2_inst", id_inst_o, 0);
        check("t2_pc", id_pc_o, 32'hbfc00002);
        check("t2_exc", id_exc_type_o, 32'h80000000);
        tick;
        check("t2_pulse", id_valid_o, 0);
        check("t2_noreq2", inst_req_o, 0);

        // addr_ok delayed 3 cycles, cached, low PC bits masked
        pc_i = 32'hbfc00106; inst_ren_i = 1; inst_cache_ena_i = 1;
        tick; inst_ren_i = 0; inst_cache_ena_i = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) inst_addr_ok_i = 1;
            check("t3_req", inst_req_o, 1);
            check("t3_addr", inst_addr_o, 32'hbfc00104);
            check("t3_cached", inst_cached_o, 1);
            check("t3_stall", fetch_stall_req_o, 1);
            tick;
        end
        inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h11112222;
        check("t3_stall_wait", fetch_stall_req_o, 1);
        tick; inst_data_ok_i = 0;
        check("t3_valid", id_valid_o, 1);
        check("t3_pc", id_pc_o, 32'hbfc00106);
        check("t3_inst", id_inst_o, 32'h11112222);
        tick;

        // flush in WAIT: response dropped, next fetch works
        pc_i = 32'hbfc00200; inst_ren_i = 1;
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        tick; inst_addr_ok_i = 0; flush_i = 1;
        check("t4_stall_w", fetch_stall_req_o, 1);
        tick; flush_i = 0;
        check("t4_valid0", id_valid_o, 0);
        check("t4_cancel_stall", fetch_stall_req_o, 1);
        check("t4_noreq", inst_req_o, 0);
        tick; inst_data_ok_i = 1; inst_rdata_i = 32'hdeadbeef;
        check("t4_valid1", id_valid_o, 0);
        tick; inst_data_ok_i = 0;
        check("t4_valid2", id_valid_o, 0);
        check("t4_cancel_clr", fetch_stall_req_o, 0);
        pc_i = 32'h80000180; inst_ren_i = 1;
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        check("t4_req2", inst_req_o, 1);
        check("t4_addr2", inst_addr_o, 32'h80000180);
        tick; inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h0000000c;
        tick; inst_data_ok_i = 0;
        check("t4_valid3", id_valid_o, 1);
        check("t4_pc3", id_pc_o, 32'h80000180);
        check("t4_inst3", id_inst_o, 32'h0000000c);
        tick;

        // decode stall: output held 3 cycles, no new request until release
        pc_i = 32'hbfc00300; inst_ren_i = 1;
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        tick; inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'haabbccdd; id_stall_i = 1;
        tick; inst_data_ok_i = 0; pc_i = 32'hbfc00400; inst_ren_i = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) id_stall_i = 0;
            check("t5_held_valid", id_valid_o, 1);
            check("t5_held_inst", id_inst_o, 32'haabbccdd);
            check("t5_held_pc", id_pc_o, 32'hbfc00300);
            check("t5_noreq", inst_req_o, 0);
            tick;
        end
        check("t5_released", id_valid_o, 0);
        check("t5_noreq_idle", inst_req_o, 0);
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        check("t5_newreq", inst_req_o, 1);
        check("t5_newaddr", inst_addr_o, 32'hbfc00400);
        tick; inst_addr_ok_i = 0; inst_data_ok_i = 1; inst_rdata_i = 32'h55667788;
        tick; inst_data_ok_i = 0;
        check("t5_inst2", id_inst_o, 32'h55667788);
        tick;

        // flush overrides ren in IDLE
        pc_i = 32'hbfc00500; inst_ren_i = 1; flush_i = 1;
        tick; inst_ren_i = 0; flush_i = 0;
        check("t6_noreq", inst_req_o, 0);
        check("t6_nostall", fetch_stall_req_o, 0);
        check("t6_novalid", id_valid_o, 0);

`ifdef INST_FETCH_PERF_EN
        reset_i = 1; tick; reset_i = 0;
        check("perf_rst", fetch_stall_cycles_o, 0);
        pc_i = 32'hbfc00600; inst_ren_i = 1;
        tick; inst_ren_i = 0; inst_addr_ok_i = 1;
        tick; inst_addr_ok_i = 0;
        tick; inst_data_ok_i = 1; inst_rdata_i = 32'h12345678;
        tick; inst_data_ok_i = 0;
        check("perf_valid", id_valid_o, 1);
        check("perf_cnt", fetch_stall_cycles_o, 3);
        tick;
        check("perf_cnt_idle", fetch_stall_cycles_o, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
